// File: rtl/rc_pulse_capture.sv
// rc_pulse_capture: measures RC receiver PWM high times in us on up to 8 pins, bus-mapped with level interrupt.
// Define RC_CAPTURE_FILTER_EN to insert a 4-Clk glitch filter after the synchronizer.
module rc_pulse_capture #(
  parameter int CHANNELS   = 8,
  parameter int PRESCALE   = 50,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [3:0]          Addr,
  input  logic [15:0]         DataWr,
  output logic [15:0]         DataRd,
  input  logic                En,
  input  logic                Rd,
  input  logic                Wr,
  input  logic [CHANNELS-1:0] PIn,
  output logic                IntStatus,
  input  logic                IntReset
);
  localparam logic [15:0] L_PRE = 16'(PRESCALE - 1);
  localparam logic [15:0] L_MIN = 16'(MIN_US);
  localparam logic [15:0] L_MAX = 16'(MAX_US);
  localparam logic [15:0] L_TO  = 16'(TIMEOUT_US);
  localparam logic [3:0]  L_CH  = 4'(CHANNELS);
  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH, ABORT} state_t;
  state_t              r_st [CHANNELS];
  state_t              w_nx [CHANNELS];
  logic [15:0]         r_cnt [CHANNELS];
  logic [15:0]         r_age [CHANNELS];
  logic [15:0]         r_width [CHANNELS];
  logic [15:0]         r_pre;
  logic [2:0]          r_warm;
  logic [CHANNELS-1:0] r_s1, r_s2, r_s3, r_valid, r_new, r_inten;
  logic [CHANNELS-1:0] w_lvl, w_rise, w_fall, w_cap, w_clr;
  logic                w_tick, w_warm, w_unused;
  assign w_unused = &{1'b0, Rd, DataWr};
  assign w_tick   = r_pre == L_PRE;
  // Pipeline flops hold reset zeros rather than the pin; WAIT_LOW trusts the level only once refilled.
  assign w_warm   = &r_warm;
  assign w_rise   = w_lvl & ~r_s3;
  assign w_fall   = ~w_lvl & r_s3;
  assign w_clr    = ({CHANNELS{En && Wr && Addr == 4'd9}} & DataWr[CHANNELS-1:0]) | {CHANNELS{IntReset}};
`ifdef RC_CAPTURE_FILTER_EN
  logic [CHANNELS-1:0] r_flt;
  logic [1:0]          r_fc [CHANNELS];
  assign w_lvl = r_flt;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_flt <= '0;
      for (int c = 0; c < CHANNELS; c++) r_fc[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_fc[c]  <= (r_s2[c] == r_flt[c] || r_fc[c] == 2'd3) ? 2'd0 : r_fc[c] + 2'd1;
        r_flt[c] <= (r_s2[c] != r_flt[c] && r_fc[c] == 2'd3) ? r_s2[c] : r_flt[c];
      end
    end
  end
`else
  assign w_lvl = r_s2;
`endif
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_nx[c]  = r_st[c];
      w_cap[c] = 1'b0;
      case (r_st[c])
        WAIT_LOW: w_nx[c] = (w_warm && !w_lvl[c]) ? IDLE : WAIT_LOW;
        IDLE:     w_nx[c] = w_rise[c] ? HIGH : IDLE;
        HIGH: begin
          w_nx[c]  = w_fall[c] ? IDLE : (w_tick && r_cnt[c] == L_MAX) ? ABORT : HIGH;
          w_cap[c] = w_fall[c] && r_cnt[c] >= L_MIN && r_cnt[c] <= L_MAX;
        end
        default:  w_nx[c] = w_fall[c] ? IDLE : ABORT;
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pre     <= '0;
      r_warm    <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_valid   <= '0;
      r_new     <= '0;
      r_inten   <= '0;
      IntStatus <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_st[c]    <= WAIT_LOW;
        r_cnt[c]   <= '0;
        r_age[c]   <= '0;
        r_width[c] <= '0;
      end
    end else begin
      r_pre     <= w_tick ? '0 : r_pre + 16'd1;
      r_warm    <= r_warm + {2'b0, ~w_warm};
      r_s1      <= PIn;
      r_s2      <= r_s1;
      r_s3      <= w_lvl;
      r_new     <= (r_new & ~w_clr) | w_cap;
      r_inten   <= (En && Wr && Addr == 4'd10) ? DataWr[CHANNELS-1:0] : r_inten;
      IntStatus <= |(r_new & r_inten);
      for (int c = 0; c < CHANNELS; c++) begin
        r_st[c]    <= w_nx[c];
        r_cnt[c]   <= (r_st[c] == IDLE) ? '0 :
                      (r_st[c] == HIGH && w_tick && !w_fall[c] && r_cnt[c] != L_MAX) ? r_cnt[c] + 16'd1 : r_cnt[c];
        r_width[c] <= w_cap[c] ? r_cnt[c] : r_width[c];
        r_age[c]   <= w_cap[c] ? '0 : (w_tick && r_age[c] != L_TO) ? r_age[c] + 16'd1 : r_age[c];
        r_valid[c] <= w_cap[c] | (r_valid[c] & (r_age[c] != L_TO));
      end
    end
  end
  assign DataRd = (Addr < L_CH)  ? r_width[Addr[2:0]] :
                  (Addr == 4'd8)  ? 16'(r_valid) :
                  (Addr == 4'd9)  ? 16'(r_new) :
                  (Addr == 4'd10) ? 16'(r_inten) :
                  (Addr == 4'd11) ? 16'(CHANNELS) : 16'd0;
endmodule

// File: doc/rc_pulse_capture.md
Name: rc_pulse_capture

Overview:
- Captures hobby RC receiver PWM pulses (1000–2000 us nominal) on up to 8 input pins and measures each high time in microseconds.
- This is the receive-side counterpart of the RC servo pulse generator: it decodes the same pulse format that the servo block emits.
- Sits on the Primary bus decode with the same En/Rd/Wr/DataRd scheme as the other peripherals.
- Raises a level interrupt into the Primary interrupt status vector when new widths arrive.

Parameters:
- CHANNELS, 8, number of input channels (1..8).
- PRESCALE, 50, Clk cycles per 1 us tick (50 MHz Clk).
- MIN_US, 500, shortest accepted pulse in us.
- MAX_US, 2500, longest accepted pulse in us.
- TIMEOUT_US, 25000, time without a valid pulse before a channel's valid bit drops.

Ports:
- Clk  input  1  system clock, only clock in block.
- Reset  input  1  synchronous, active-high reset.
- Addr  input  4  word address, from bus Addr[4:1].
- DataWr  input  16  write data.
- DataRd  output  16  read data, combinational from Addr.
- En  input  1  block select from top-level decode.
- Rd  input  1  read strobe, no side effects.
- Wr  input  1  write strobe, one-cycle qualified.
- PIn  input  CHANNELS  asynchronous RC pulse inputs.
- IntStatus  output  1  level interrupt request.
- IntReset  input  1  one-cycle pulse that clears all new-data bits.

Behaviour:
- Interface: one clock, Clk; Reset is synchronous and active-high, sampled on rising Clk.
- Reset values:
  - IntStatus = 0.
  - All width registers, valid, new and inten bits = 0.
  - Prescaler and age counters = 0.
  - Synchronizers = 0.
  - Every channel state = WAIT_LOW.
- Tick: prescaler counts 0..PRESCALE-1. tick = 1 for one Clk when count == PRESCALE-1, then the count wraps to 0.
- Per-channel input path:
  - 2-flop synchronizer s1 -> s2, plus history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Input-to-edge latency is 3 Clk.
- Per-channel FSM:
  - WAIT_LOW: go to IDLE when s2 == 0. This prevents capturing a partial pulse that was already high at reset release.
  - IDLE: on rise, set cnt = 0 and go to HIGH.
  - HIGH:
    - On tick, cnt increments.
    - If a tick would take cnt to MAX_US+1, go to ABORT; nothing is captured.
    - On fall, go to IDLE. If MIN_US <= cnt <= MAX_US: width <= cnt, valid <= 1, new <= 1, age <= 0. Otherwise the pulse is discarded and width is unchanged.
  - ABORT: on fall, go to IDLE. No capture.
  - cnt is 16 bits. Measured width = ticks seen while high, accurate to ±1 us.
- Simultaneous events:
  - fall and tick in the same cycle: the pre-increment cnt is used.
  - rise and tick: cnt = 0.
  - Capture and clear (W1C or IntReset) of a new bit: set wins.
- Age / stale:
  - Per-channel 16-bit age counter increments on tick and saturates at TIMEOUT_US.
  - When age == TIMEOUT_US, valid <= 0. width keeps its last value.
- Register map (word addresses, reads have no side effects; unmapped reads return 0, unmapped writes are ignored):
  - 0..CHANNELS-1: width[ch] in us, read-only.
  - 8: valid[CHANNELS-1:0], read-only.
  - 9: new[CHANNELS-1:0]. A write clears the bits where DataWr = 1 (W1C).
  - 10: inten[CHANNELS-1:0], read/write.
  - 11: constant CHANNELS in [3:0], read-only.
- Write effects: occur on the Clk where En & Wr = 1. Writes to read-only addresses are ignored.
- IntStatus: registered, = |(new & inten). It updates 1 Clk after new or inten change.
- Reset asserted mid-pulse: the channel returns to WAIT_LOW and all captured state is lost.

Optional Feature:
- Macro: RC_CAPTURE_FILTER_EN.
- When defined: s2 feeds a 4-cycle glitch filter, and the filtered level changes only after s2 has been stable for 4 consecutive Clk. Edge latency becomes 7 Clk, and pulses shorter than 4 Clk are ignored.
- When undefined: no filter; latency is 3 Clk, as above.

Test Plan:
- Reset release, then a 1500 us high pulse on PIn[0] -> width[0] = 1500±1, valid = 0x01, new = 0x01. With inten = 0x01, IntStatus = 1 one Clk after capture.
- PIn[2] held high through Reset release for 800 us, followed by a 1200 us pulse -> the first pulse is ignored (WAIT_LOW) and width[2] = 1200±1.
- 300 us pulse and 3000 us pulse on channel 1 -> both are discarded and width[1] is unchanged. The 3000 us pulse passes through ABORT, and the next 1000 us pulse captures 1000±1.
- After a valid capture on channel 3, no pulses for 25 ms -> valid bit 3 = 0 at 25000 ticks and width[3] is retained.
- Write 0x0001 to address 9 on the same Clk as a channel 0 capture -> new[0] stays 1. A later write clears it, and IntStatus = 0 on the next Clk.
- With RC_CAPTURE_FILTER_EN defined: a 2-Clk glitch on PIn[4] -> no state change. A 1500 us pulse -> 1500±1.
